type_param_deserializer: RTL and testbench

- Receiver end of a type-parameterized narrow stream: accepts fixed-width words over valid/ready and reassembles them into one payload of caller-supplied type T.
- Mirror of the sender that slices a T-typed payload into words; the two are instantiated with identical T and WORD_WIDTH.
- Double-buffered, so collection of frame N+1 overlaps the wait on the consumer for frame N.

---
 rtl/type_param_deser_pkg.sv | 16 +
 rtl/type_param_deser_outbuf.sv | 44 ++++
 rtl/type_param_deserializer.sv | 107 ++++++++++
 tb/tb_type_param_deserializer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/type_param_deser_pkg.sv
// Shared types and helpers for the type-parameterized stream deserializer.
package type_param_deser_pkg;

  typedef enum logic {
    COLLECT   = 1'b0,
    HOLD_FULL = 1'b1
  } deser_state_e;

  // Number of stream words needed to carry one payload, never below one.
  function automatic int calc_beats(input int payload_width, input int word_width);
    int beats;
    beats = (payload_width + word_width - 1) / word_width;
    return (beats < 1) ? 1 : beats;
  endfunction

endpackage

// File: rtl/type_param_deser_outbuf.sv
// One-entry register slice holding an assembled payload of type T until the consumer takes it.
module type_param_deser_outbuf
  import type_param_deser_pkg::*;
#(
  parameter type T = logic [32-1:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  T     load_data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  deser_state_e state_q, state_d;
  T             data_q, data_d;

  // A load wins over a drain, so a simultaneous transfer and refill keeps the slot full.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      state_d = HOLD_FULL;
      data_d  = load_data_i;
    end else if (state_q == HOLD_FULL && ready_i) begin
      state_d = COLLECT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == HOLD_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/type_param_deserializer.sv
// Reassembles little-endian stream words into one T-typed payload, double-buffered against the consumer.
module type_param_deserializer
  import type_param_deser_pkg::*;
#(
  parameter type T          = logic [32-1:0],
  parameter int  WORD_WIDTH = 8,
  parameter int  CNT_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  input  logic [WORD_WIDTH-1:0] i_word_data,
  input  logic                  i_word_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output T                      o_data,
  output logic                  o_err,
  output logic [CNT_WIDTH-1:0]  o_drop_count
);

  localparam int PAYLOAD_WIDTH = $bits(T);
  localparam int BEATS         = calc_beats(PAYLOAD_WIDTH, WORD_WIDTH);
  localparam int BEAT_IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ASM_WIDTH     = BEATS * WORD_WIDTH;
  localparam int LAST_LSB      = (BEATS - 1) * WORD_WIDTH;
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  logic [BEAT_IDX_W-1:0] beat_q, beat_d;
  logic [ASM_WIDTH-1:0]  asm_q, asm_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;

  logic                  at_last;
  logic                  accept;
  logic                  load;
  logic                  out_valid;
  logic [ASM_WIDTH-1:0]  full_word;
  T                      payload;

  assign at_last      = (beat_q == LAST_BEAT);
  assign o_word_ready = !(at_last && out_valid && !i_ready);
  assign accept       = i_word_valid && o_word_ready;

  // The final word goes straight into the payload; it is never parked in the assembly buffer.
  always_comb begin
    full_word = asm_q;
    full_word[LAST_LSB +: WORD_WIDTH] = i_word_data;
  end

  assign payload = T'(full_word[PAYLOAD_WIDTH-1:0]);

  always_comb begin
    beat_d = beat_q;
    asm_d  = asm_q;
    err_d  = 1'b0;
    drop_d = drop_q;
    load   = 1'b0;
    if (accept) begin
      if (at_last && i_word_last) begin
        load   = 1'b1;
        beat_d = '0;
      end else if (!at_last && !i_word_last) begin
        asm_d[beat_q*WORD_WIDTH +: WORD_WIDTH] = i_word_data;
        beat_d = beat_q + 1'b1;
      end else begin
        // Early or missing last: drop the frame and count it, leaving the output buffer alone.
        beat_d = '0;
        err_d  = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_q <= '0;
      asm_q  <= '0;
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      beat_q <= beat_d;
      asm_q  <= asm_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  type_param_deser_outbuf #(
    .T(T)
  ) u_outbuf (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .load_i      (load),
    .load_data_i (payload),
    .valid_o     (out_valid),
    .ready_i     (i_ready),
    .data_o      (o_data)
  );

  assign o_valid      = out_valid;
  assign o_err        = err_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_type_param_deserializer.sv
// Directed bench for type_param_deserializer: 20-bit payloads, a saturating 2-bit drop counter, and a one-beat struct payload.
module tb_type_param_deserializer;

  typedef struct packed {
    logic       a;
    logic [5:0] b;
  } pair_t;

  logic clk;
  logic rst;

  logic        mValid, mLast, mReady, mWordReady, mOutValid, mErr;
  logic [7:0]  mData, mDrop;
  logic [19:0] mOutData;

  logic        sValid, sLast, sReady, sWordReady, sOutValid, sErr;
  logic [7:0]  sData;
  logic [1:0]  sDrop;
  logic [19:0] sOutData;

  logic        tValid, tLast, tReady, tWordReady, tOutValid, tErr;
  logic [7:0]  tData, tDrop;
  pair_t       tOutData;

  int checks;
  int failures;
  int transfers;
  int errSeen;
  int stalls;
  logic [19:0] expQ[$];

  type_param_deserializer #(.T(logic [19:0]), .WORD_WIDTH(8), .CNT_WIDTH(8)) dutMain (
    .i_clk(clk), .i_rst(rst), .i_word_valid(mValid), .o_word_ready(mWordReady),
    .i_word_data(mData), .i_word_last(mLast), .o_valid(mOutValid), .i_ready(mReady),
    .o_data(mOutData), .o_err(mErr), .o_drop_count(mDrop)
  );

  type_param_deserializer #(.T(logic [19:0]), .WORD_WIDTH(8), .CNT_WIDTH(2)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_word_valid(sValid), .o_word_ready(sWordReady),
    .i_word_data(sData), .i_word_last(sLast), .o_valid(sOutValid), .i_ready(sReady),
    .o_data(sOutData), .o_err(sErr), .o_drop_count(sDrop)
  );

  type_param_deserializer #(.T(pair_t), .WORD_WIDTH(8), .CNT_WIDTH(8)) dutStruct (
    .i_clk(clk), .i_rst(rst), .i_word_valid(tValid), .o_word_ready(tWordReady),
    .i_word_data(tData), .i_word_last(tLast), .o_valid(tOutValid), .i_ready(tReady),
    .o_data(tOutData), .o_err(tErr), .o_drop_count(tDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every payload the main instance hands over is matched against the oldest pushed frame.
  always @(negedge clk) begin
    if (!rst && mOutValid && mReady) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedValid", {31'b0, mOutValid}, 32'd0);
      end else begin
        checkOutput("payload", {12'b0, mOutData}, {12'b0, expQ.pop_front()});
        transfers++;
      end
    end
    if (mErr) errSeen++;
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleMain();
    mValid = 1'b0;
    mLast  = 1'b0;
    mData  = 8'h00;
  endtask

  // Offers one word to the main instance and holds it until the handshake edge has passed.
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    logic done;
    done   = 1'b0;
    mValid = 1'b1;
    mData  = data;
    mLast  = last;
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = mWordReady;
      if (!done) stalls++;
      stepCycle();
    end
    if (!done) checkOutput("handshakeTimeout", {31'b0, done}, 32'd1);
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [23:0] full;
    full = {b2, b1, b0};
    expQ.push_back(full[19:0]);
    applyStimulus(b0, 1'b0);
    applyStimulus(b1, 1'b0);
    applyStimulus(b2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int errBase;
    int stallBase;
    logic [7:0] r0, r1, r2;

    checks = 0; failures = 0; transfers = 0; errSeen = 0; stalls = 0;
    rst = 1'b1;
    idleMain();
    mReady = 1'b1;
    sValid = 1'b0; sLast = 1'b0; sData = 8'h00; sReady = 1'b1;
    tValid = 1'b0; tLast = 1'b0; tData = 8'h00; tReady = 1'b1;
    repeat (2) stepCycle();
    rst = 1'b0;
    stepCycle();

    $display("[TB] reset state");
    checkOutput("rstValid", {31'b0, mOutValid}, 32'd0);
    checkOutput("rstData", {12'b0, mOutData}, 32'd0);
    checkOutput("rstErr", {31'b0, mErr}, 32'd0);
    checkOutput("rstDrop", {24'b0, mDrop}, 32'd0);
    checkOutput("rstWordReady", {31'b0, mWordReady}, 32'd1);

    $display("[TB] single frame, top nibble truncated");
    expQ.push_back(20'h51234);
    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h12, 1'b0);
    checkOutput("validBeforeFinal", {31'b0, mOutValid}, 32'd0);
    applyStimulus(8'hA5, 1'b1);
    checkOutput("latencyValid", {31'b0, mOutValid}, 32'd1);
    checkOutput("firstData", {12'b0, mOutData}, 32'h51234);
    idleMain();
    stepCycle();
    checkOutput("validDropsAfterXfer", {31'b0, mOutValid}, 32'd0);
    checkOutput("noErrGoodFrame", errSeen, 32'd0);

    $display("[TB] four back-to-back frames");
    base = transfers;
    stallBase = stalls;
    for (int f = 0; f < 4; f++) begin
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      sendFrame(r0, r1, r2);
    end
    idleMain();
    repeat (2) stepCycle();
    checkOutput("streamNoStall", stalls - stallBase, 32'd0);
    checkOutput("streamCount", transfers - base, 32'd4);
    checkOutput("streamQueueEmpty", expQ.size(), 32'd0);

    $display("[TB] backpressure on second frame");
    base = transfers;
    mReady = 1'b0;
    sendFrame(8'h11, 8'h22, 8'h33);
    stallBase = stalls;
    expQ.push_back(20'h6C5B4);
    applyStimulus(8'hB4, 1'b0);
    applyStimulus(8'hC5, 1'b0);
    checkOutput("nonFinalAccepted", stalls - stallBase, 32'd0);
    mValid = 1'b1; mData = 8'hD6; mLast = 1'b1;
    #1;
    checkOutput("readyDropsOnFinal", {31'b0, mWordReady}, 32'd0);
    repeat (2) stepCycle();
    checkOutput("heldValid", {31'b0, mOutValid}, 32'd1);
    checkOutput("heldData", {12'b0, mOutData}, 32'h32211);
    checkOutput("stillNotReady", {31'b0, mWordReady}, 32'd0);
    mReady = 1'b1;
    #1;
    checkOutput("readyCombRelease", {31'b0, mWordReady}, 32'd1);
    stepCycle();
    checkOutput("secondLoaded", {12'b0, mOutData}, 32'h6C5B4);
    idleMain();
    repeat (2) stepCycle();
    checkOutput("bpDelivered", transfers - base, 32'd2);

    $display("[TB] framing errors");
    base = transfers;
    errBase = errSeen;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b1);
    checkOutput("errEarlyLast", {31'b0, mErr}, 32'd1);
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h04, 1'b0);
    applyStimulus(8'h05, 1'b0);
    checkOutput("errMissingLast", {31'b0, mErr}, 32'd1);
    idleMain();
    stepCycle();
    checkOutput("errPulseEnds", {31'b0, mErr}, 32'd0);
    checkOutput("errPulseCount", errSeen - errBase, 32'd2);
    checkOutput("dropCount2", {24'b0, mDrop}, 32'd2);
    checkOutput("noValidOnErr", transfers - base, 32'd0);
    sendFrame(8'hEF, 8'hBE, 8'h0D);
    idleMain();
    repeat (2) stepCycle();
    checkOutput("goodAfterErr", transfers - base, 32'd1);

    $display("[TB] reset mid-frame");
    base = transfers;
    errBase = errSeen;
    applyStimulus(8'h0A, 1'b0);
    applyStimulus(8'h0B, 1'b0);
    idleMain();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("rstNoErr", errSeen - errBase, 32'd0);
    checkOutput("rstDropCleared", {24'b0, mDrop}, 32'd0);
    checkOutput("rstNoValid", {31'b0, mOutValid}, 32'd0);
    sendFrame(8'hC1, 8'hC2, 8'hC3);
    idleMain();
    repeat (2) stepCycle();
    checkOutput("freshFrame", transfers - base, 32'd1);
    checkOutput("freshFrameNoErr", errSeen - errBase, 32'd0);
    checkOutput("queueDrained", expQ.size(), 32'd0);

    $display("[TB] drop counter saturation");
    sValid = 1'b1; sLast = 1'b1; sData = 8'h5A;
    repeat (3) stepCycle();
    checkOutput("satReach3", {30'b0, sDrop}, 32'd3);
    repeat (2) stepCycle();
    checkOutput("satHold3", {30'b0, sDrop}, 32'd3);
    checkOutput("satErrStillPulses", {31'b0, sErr}, 32'd1);
    checkOutput("satNoValid", {31'b0, sOutValid}, 32'd0);
    sValid = 1'b0; sLast = 1'b0;
    stepCycle();
    checkOutput("satErrClear", {31'b0, sErr}, 32'd0);

    $display("[TB] struct payload, one beat per frame");
    tValid = 1'b1; tLast = 1'b1; tData = 8'hAA;
    stepCycle();
    checkOutput("structValid", {31'b0, tOutValid}, 32'd1);
    checkOutput("structA0", {31'b0, tOutData.a}, 32'd0);
    checkOutput("structB0", {26'b0, tOutData.b}, 32'h2A);
    tData = 8'h55;
    stepCycle();
    checkOutput("structA1", {31'b0, tOutData.a}, 32'd1);
    checkOutput("structB1", {26'b0, tOutData.b}, 32'h15);
    tLast = 1'b0; tData = 8'h7F;
    stepCycle();
    checkOutput("structErrB", {31'b0, tErr}, 32'd1);
    checkOutput("structDrop", {24'b0, tDrop}, 32'd1);
    checkOutput("structNoValid", {31'b0, tOutValid}, 32'd0);
    tValid = 1'b0;
    stepCycle();
    checkOutput("structErrClear", {31'b0, tErr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
